cpu_run_controller: RTL and testbench

Debug run-control sequencer for the single-cycle RV32 core. It gates the core's clock enable (cpu_en covers the PC, register-file and data-memory write enables) and supports halt, free run, N-instruction stepping and two PC breakpoints. It also counts retired instructions. It sits between a host command port and the core; pc and instr come from the core's fetch stage.

---
 rtl/cpu_run_controller.sv | 156 +++++++++++++++
 tb/tb_cpu_run_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - debug run-control sequencer (halt/run/step/breakpoints, retire count)
// Optional EBREAK halt enabled by defining RUN_CTRL_EBREAK_EN.
module cpu_run_controller #(
    parameter int CNT_W      = 32,
    parameter int MAX_STEP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_arg,
    output logic             rsp_valid,
    output logic [31:0]      rsp_data,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    output logic             cpu_en,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] retired
);
    localparam logic [1:0] ST_HALTED = 2'd0, ST_RUN = 2'd1, ST_STEP = 2'd2;
    localparam logic [1:0] CAUSE_HOST = 2'd0, CAUSE_BKPT = 2'd1, CAUSE_STEP = 2'd2, CAUSE_EBREAK = 2'd3;
    localparam logic [2:0] OP_HALT = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3, OP_SET_BKPT = 3'd4,
                           OP_CLR_BKPT = 3'd5, OP_CLR_COUNT = 3'd6, OP_READ_COUNT = 3'd7;

    logic [1:0]            state_q, state_d;
    logic [1:0]            cause_q, cause_d;
    logic [MAX_STEP_W-1:0] remaining_q, remaining_d;
    logic                  skip_first_q, skip_first_d;
    logic [31:0]           bp_addr_q [2];
    logic [31:0]           bp_addr_d [2];
    logic [1:0]            bp_en_q, bp_en_d;
    logic [CNT_W-1:0]      retired_q, retired_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_data_q, rsp_data_d;

    logic        accept, running, bkpt_hit, stop, ebreak_stop, en;
    logic [31:0] pc_word;
    logic        unused_pc_lo;

    assign accept   = cmd_valid & ~rsp_valid_q;
    assign running  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign pc_word  = {pc[31:2], 2'b00};
    assign bkpt_hit = (bp_en_q[0] && (pc_word == bp_addr_q[0])) ||
                      (bp_en_q[1] && (pc_word == bp_addr_q[1]));
    // skip_first lets execution resume from the very PC that caused the halt
    assign stop     = running & bkpt_hit & ~skip_first_q;
    assign unused_pc_lo = ^pc[1:0];
`ifdef RUN_CTRL_EBREAK_EN
    assign ebreak_stop = running & (instr == 32'h0010_0073) & ~skip_first_q;
`else
    logic unused_instr;
    assign unused_instr = ^instr;
    assign ebreak_stop  = 1'b0;
`endif
    assign en = running & ~stop & ~ebreak_stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_HALTED;
            cause_q      <= CAUSE_HOST;
            remaining_q  <= '0;
            skip_first_q <= 1'b0;
            bp_addr_q[0] <= '0;
            bp_addr_q[1] <= '0;
            bp_en_q      <= '0;
            retired_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            remaining_q  <= remaining_d;
            skip_first_q <= skip_first_d;
            bp_addr_q[0] <= bp_addr_d[0];
            bp_addr_q[1] <= bp_addr_d[1];
            bp_en_q      <= bp_en_d;
            retired_q    <= retired_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        remaining_d  = remaining_q;
        skip_first_d = skip_first_q;
        case (state_q)
            ST_HALTED: begin
                if (accept && cmd_op == OP_HALT) begin
                    cause_d = CAUSE_HOST;
                end else if (accept && cmd_op == OP_RUN) begin
                    state_d      = ST_RUN;
                    skip_first_d = 1'b1;
                end else if (accept && cmd_op == OP_STEP) begin
                    state_d      = ST_STEP;
                    skip_first_d = 1'b1;
                    remaining_d  = (cmd_arg[MAX_STEP_W-1:0] == '0) ? MAX_STEP_W'(1)
                                                                   : cmd_arg[MAX_STEP_W-1:0];
                end
            end
            ST_RUN, ST_STEP: begin
                if (en) begin
                    skip_first_d = 1'b0;
                    if (state_q == ST_STEP) remaining_d = remaining_q - MAX_STEP_W'(1);
                end
                if (stop) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BKPT;
                end else if (ebreak_stop) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_EBREAK;
                end else if (accept && cmd_op == OP_HALT) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_HOST;
                end else if (state_q == ST_STEP && remaining_q == MAX_STEP_W'(1)) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_STEP;
                end
            end
            default: state_d = ST_HALTED;
        endcase

        bp_addr_d = bp_addr_q;
        bp_en_d   = bp_en_q;
        if (accept && cmd_op == OP_SET_BKPT) begin
            bp_addr_d[cmd_arg[0]] = {cmd_arg[31:2], 2'b00};
            bp_en_d[cmd_arg[0]]   = 1'b1;
        end else if (accept && cmd_op == OP_CLR_BKPT) begin
            bp_en_d[cmd_arg[0]] = 1'b0;
        end

        retired_d = retired_q;
        if (accept && cmd_op == OP_CLR_COUNT) retired_d = '0;
        else if (en && !(&retired_q))         retired_d = retired_q + CNT_W'(1);

        rsp_valid_d = accept;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            if (cmd_op == OP_READ_COUNT) rsp_data_d = 32'(retired_q);
            else                         rsp_data_d = {28'b0, state_q, cause_q};
        end
    end

    always_comb begin
        cpu_en     = en;
        halted     = (state_q == ST_HALTED);
        halt_cause = cause_q;
        retired    = retired_q;
        cmd_ready  = ~rsp_valid_q;
        rsp_valid  = rsp_valid_q;
        rsp_data   = rsp_data_q;
    end
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed self-checking bench for cpu_run_controller
module tb_cpu_run_controller;
    localparam int CW = 4;
    localparam logic [2:0] OP_HALT = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3, OP_SET_BKPT = 3'd4,
                           OP_CLR_BKPT = 3'd5, OP_CLR_COUNT = 3'd6, OP_READ_COUNT = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [31:0]   cmd_arg = 32'd0;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [31:0]   pc = 32'd0;
    logic [31:0]   instr;
    logic          cpu_en;
    logic          halted;
    logic [1:0]    halt_cause;
    logic [CW-1:0] retired;

    logic          pc_load = 1'b0;
    logic [31:0]   pc_load_val = 32'd0;
    logic [31:0]   ebreak_pc = 32'hFFFF_FFF0;
    int            errors = 0;
    int            checks = 0;
    int            n;

    cpu_run_controller #(.CNT_W(CW), .MAX_STEP_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .pc(pc), .instr(instr), .cpu_en(cpu_en), .halted(halted),
        .halt_cause(halt_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    // Minimal core: PC advances by 4 on every enabled cycle
    always @(posedge clk) begin
        if (pc_load)     pc <= pc_load_val;
        else if (cpu_en) pc <= pc + 32'd4;
    end
    assign instr = (pc == ebreak_pc) ? 32'h0010_0073 : 32'h0000_0013;

    task automatic issue(input logic [2:0] op, input logic [31:0] arg);
        int w = 0;
        while (!cmd_ready && w < 4) begin @(negedge clk); w++; end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_load = 1'b1; pc_load_val = v;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    task automatic run_cycles(input int cyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < cyc; i++) begin
            if (cpu_en) cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rst_halted: got %b want 1", halted); end
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL rst_cpu_en: got %b want 0", cpu_en); end
        checks++; if (halt_cause !== 2'd0) begin errors++; $display("FAIL rst_cause: got %0d want 0", halt_cause); end
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL rst_retired: got %0d want 0", retired); end
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
            errors++; $display("FAIL rst_handshake: ready=%b valid=%b data=%h want 1 0 0", cmd_ready, rsp_valid, rsp_data); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_handshake;
        issue(OP_READ_COUNT, 32'd0);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0) begin
            errors++; $display("FAIL rd_rsp: valid=%b data=%h want 1 0", rsp_valid, rsp_data); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_low: got %b want 0", cmd_ready); end
        // RUN offered while not ready must be dropped
        cmd_valid = 1'b1; cmd_op = OP_RUN;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rsp_one_cycle: valid=%b ready=%b want 0 1", rsp_valid, cmd_ready); end
        checks++; if (halted !== 1'b1 || cpu_en !== 1'b0) begin
            errors++; $display("FAIL ignored_cmd: halted=%b cpu_en=%b want 1 0", halted, cpu_en); end
    endtask

    task automatic test_step;
        issue(OP_STEP, 32'd3);
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL step3_rsp: got %h want 0", rsp_data); end
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL step3_first: cpu_en=%b want 1", cpu_en); end
        run_cycles(6, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL step3_cycles: got %0d want 3", n); end
        checks++; if (halted !== 1'b1 || halt_cause !== 2'd2 || retired !== 4'd3) begin
            errors++; $display("FAIL step3_end: halted=%b cause=%0d retired=%0d want 1 2 3", halted, halt_cause, retired); end
        issue(OP_STEP, 32'd0);
        checks++; if (rsp_data !== 32'd2) begin errors++; $display("FAIL step0_rsp: got %h want 2", rsp_data); end
        run_cycles(4, n);
        checks++; if (n !== 1 || retired !== 4'd4 || halt_cause !== 2'd2) begin
            errors++; $display("FAIL step0: cycles=%0d retired=%0d cause=%0d want 1 4 2", n, retired, halt_cause); end
        issue(OP_CLR_COUNT, 32'd0);
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL clr_halted: got %0d want 0", retired); end
    endtask

    task automatic test_breakpoint;
        issue(OP_SET_BKPT, 32'h10);
        load_pc(32'd0);
        issue(OP_RUN, 32'd0);
        checks++; if (rsp_data !== 32'd2) begin errors++; $display("FAIL run_rsp: got %h want 2", rsp_data); end
        run_cycles(8, n);
        checks++; if (n !== 4 || pc !== 32'h10) begin errors++; $display("FAIL bkpt_stop: cycles=%0d pc=%h want 4 10", n, pc); end
        checks++; if (halted !== 1'b1 || halt_cause !== 2'd1 || retired !== 4'd4) begin
            errors++; $display("FAIL bkpt_state: halted=%b cause=%0d retired=%0d want 1 1 4", halted, halt_cause, retired); end
    endtask

    task automatic test_resume_saturate;
        issue(OP_RUN, 32'd0);
        checks++; if (rsp_data !== 32'd1) begin errors++; $display("FAIL resume_rsp: got %h want 1", rsp_data); end
        run_cycles(20, n);
        checks++; if (n !== 20 || halted !== 1'b0) begin errors++; $display("FAIL resume: cycles=%0d halted=%b want 20 0", n, halted); end
        checks++; if (retired !== 4'd15) begin errors++; $display("FAIL saturate: got %0d want 15", retired); end
    endtask

    task automatic test_clr_count_and_halt;
        issue(OP_CLR_COUNT, 32'd0);
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL clr_running: got %0d want 0", retired); end
        @(negedge clk);
        checks++; if (retired !== 4'd1) begin errors++; $display("FAIL clr_then_inc: got %0d want 1", retired); end
        cmd_valid = 1'b1; cmd_op = OP_HALT;
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL halt_accept_cycle: cpu_en=%b want 1", cpu_en); end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0;
        checks++; if (cpu_en !== 1'b0 || halted !== 1'b1 || halt_cause !== 2'd0) begin
            errors++; $display("FAIL halt_after: cpu_en=%b halted=%b cause=%0d want 0 1 0", cpu_en, halted, halt_cause); end
        checks++; if (rsp_data !== 32'd5 || retired !== 4'd2) begin
            errors++; $display("FAIL halt_rsp: data=%h retired=%0d want 5 2", rsp_data, retired); end
    endtask

    task automatic test_bkpt_slot1;
        issue(OP_CLR_BKPT, 32'd0);
        issue(OP_SET_BKPT, 32'h25);
        load_pc(32'd0);
        issue(OP_RUN, 32'd0);
        run_cycles(14, n);
        checks++; if (n !== 9 || pc !== 32'h24 || halt_cause !== 2'd1) begin
            errors++; $display("FAIL slot1: cycles=%0d pc=%h cause=%0d want 9 24 1", n, pc, halt_cause); end
        issue(OP_READ_COUNT, 32'd0);
        checks++; if (rsp_data !== 32'd11) begin errors++; $display("FAIL read_count: got %0d want 11", rsp_data); end
        load_pc(32'h20);
        issue(OP_STEP, 32'd2);
        run_cycles(4, n);
        checks++; if (n !== 1 || halt_cause !== 2'd1 || pc !== 32'h24) begin
            errors++; $display("FAIL step_bkpt: cycles=%0d cause=%0d pc=%h want 1 1 24", n, halt_cause, pc); end
        issue(OP_STEP, 32'd1);
        run_cycles(3, n);
        checks++; if (n !== 1 || halt_cause !== 2'd2 || pc !== 32'h28) begin
            errors++; $display("FAIL step_from_bkpt: cycles=%0d cause=%0d pc=%h want 1 2 28", n, halt_cause, pc); end
    endtask

    task automatic test_ebreak;
        issue(OP_CLR_BKPT, 32'd1);
        load_pc(32'd0);
        ebreak_pc = 32'h8;
        issue(OP_RUN, 32'd0);
        run_cycles(10, n);
`ifdef RUN_CTRL_EBREAK_EN
        checks++; if (n !== 2 || pc !== 32'h8 || halted !== 1'b1 || halt_cause !== 2'd3) begin
            errors++; $display("FAIL ebreak: cycles=%0d pc=%h halted=%b cause=%0d want 2 8 1 3", n, pc, halted, halt_cause); end
`else
        checks++; if (n !== 10 || pc !== 32'h28 || halted !== 1'b0) begin
            errors++; $display("FAIL no_ebreak: cycles=%0d pc=%h halted=%b want 10 28 0", n, pc, halted); end
        issue(OP_HALT, 32'd0);
`endif
        ebreak_pc = 32'hFFFF_FFF0;
    endtask

    task automatic test_async_reset;
        issue(OP_RUN, 32'd0);
        run_cycles(3, n);
        rst = 1'b0;
        #1;
        checks++; if (halted !== 1'b1 || cpu_en !== 1'b0 || retired !== 4'd0 || halt_cause !== 2'd0) begin
            errors++; $display("FAIL async_rst: halted=%b cpu_en=%b retired=%0d cause=%0d want 1 0 0 0", halted, cpu_en, retired, halt_cause); end
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
            errors++; $display("FAIL async_rst_rsp: ready=%b valid=%b data=%h want 1 0 0", cmd_ready, rsp_valid, rsp_data); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_handshake;
        test_step;
        test_breakpoint;
        test_resume_saturate;
        test_clr_count_and_halt;
        test_bkpt_slot1;
        test_ebreak;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
